// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute stage for the RV core. It decodes alu_op/funct7/funct3 (ALUOp
//   scheme) and registers a single-cycle ALU result or a branch outcome. An
//   optional XLEN-step shift-add / restoring-division engine covers the
//   M extension. The core stalls on busy.
//
//   Build option: define ALU_MULDIV_EN to build the iterative M-extension
//   engine. Without it, busy is tied low and funct7=0x01 R-type ops decode
//   as illegal.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   in_valid / in_ready    request handshake (accept = both high at an edge)
//   alu_op, funct7, funct3 operation selectors
//   src_a, src_b           operands (rs1, rs2/immediate)
//   out_valid              one-cycle pulse qualifying out_result/out_check/out_illegal
//   out_result             arithmetic result (0 when illegal)
//   out_check              branch condition true (branch ops only)
//   out_illegal            undecodable combination
//   busy                   iterative op in flight
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_check,
  output logic            out_illegal,
  output logic            busy
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  assign in_ready = rstn && (state == IDLE);

  // Single-cycle datapath
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    add_res, sub_res, sll_res, srl_res, sra_res, slt_res, sltu_res;
  logic               lt_s, lt_u, eq;

  assign shamt    = src_b[SHAMT_W-1:0];
  assign add_res  = src_a + src_b;
  assign sub_res  = src_a - src_b;
  assign sll_res  = src_a << shamt;
  assign srl_res  = src_a >> shamt;
  assign sra_res  = $unsigned($signed(src_a) >>> shamt);
  assign lt_s     = $signed(src_a) < $signed(src_b);
  assign lt_u     = src_a < src_b;
  assign eq       = (src_a == src_b);
  assign slt_res  = {{(XLEN-1){1'b0}}, lt_s};
  assign sltu_res = {{(XLEN-1){1'b0}}, lt_u};

  logic [XLEN-1:0] dec_result;
  logic            dec_check, dec_illegal, dec_is_m;

  always_comb begin
    dec_result  = '0;
    dec_check   = 1'b0;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    case (alu_op)
      2'b00: dec_result = add_res;
      2'b01: begin
        dec_result = sub_res;
        case (funct3)
          3'b000:  dec_check = eq;
          3'b001:  dec_check = !eq;
          3'b100:  dec_check = lt_s;
          3'b101:  dec_check = !lt_s;
          3'b110:  dec_check = lt_u;
          3'b111:  dec_check = !lt_u;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  dec_result = add_res;
            3'b001:  dec_result = sll_res;
            3'b010:  dec_result = slt_res;
            3'b011:  dec_result = sltu_res;
            3'b100:  dec_result = src_a ^ src_b;
            3'b101:  dec_result = srl_res;
            3'b110:  dec_result = src_a | src_b;
            default: dec_result = src_a & src_b;
          endcase
        end else if (funct7 == 7'h20) begin
          case (funct3)
            3'b000:  dec_result = sub_res;
            3'b101:  dec_result = sra_res;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == 7'h01) begin
`ifdef ALU_MULDIV_EN
          dec_is_m = 1'b1;
`else
          dec_illegal = 1'b1;
`endif
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        // I-type: funct7[5] only matters for the shift encodings
        case (funct3)
          3'b000:  dec_result = add_res;
          3'b001:  if (funct7[5]) dec_illegal = 1'b1; else dec_result = sll_res;
          3'b010:  dec_result = slt_res;
          3'b011:  dec_result = sltu_res;
          3'b100:  dec_result = src_a ^ src_b;
          3'b101:  dec_result = funct7[5] ? sra_res : srl_res;
          3'b110:  dec_result = src_a | src_b;
          default: dec_result = src_a & src_b;
        endcase
      end
    endcase
    if (dec_illegal) begin
      dec_result = '0;
      dec_check  = 1'b0;
    end
  end

`ifdef ALU_MULDIV_EN
  // Iterative engine. Both mul and div start from hi=0, lo=|a|, opnd=|b|;
  // signs are reapplied at the end.
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   hi, lo, opnd, a_keep;
  logic [2:0]        op_f3;
  logic              neg_q, neg_r, div_zero;
  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_diff, hi_step, lo_step, quo_fix, rem_fix, m_result;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_fix;

  // a is signed for mulh, mulhsu, div, rem; b for mulh, div, rem
  assign a_sgn = (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 ||
                  funct3 == 3'b110) && src_a[XLEN-1];
  assign b_sgn = (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110) &&
                 src_b[XLEN-1];
  assign mag_a = a_sgn ? -src_a : src_a;
  assign mag_b = b_sgn ? -src_b : src_b;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // only used when div_ge, where the true difference is below opnd
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op_f3[2]) begin
      hi_step = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_step = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = div_zero ? '1 : (neg_q ? -lo : lo);
    rem_fix  = div_zero ? a_keep : (neg_r ? -hi : hi);
    case (op_f3)
      3'b000:                 m_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: m_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         m_result = quo_fix;
      default:                m_result = rem_fix;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_check   <= 1'b0;
      out_illegal <= 1'b0;
      busy        <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt         <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MULDIV_EN
            if (dec_is_m) begin
              state    <= CALC;
              busy     <= 1'b1;
              cnt      <= CNT_W'(XLEN);
              hi       <= '0;
              lo       <= mag_a;
              opnd     <= mag_b;
              a_keep   <= src_a;
              op_f3    <= funct3;
              neg_q    <= a_sgn ^ b_sgn;
              neg_r    <= a_sgn;
              div_zero <= (src_b == '0);
            end else
`endif
            begin
              out_valid   <= 1'b1;
              out_result  <= dec_result;
              out_check   <= dec_check;
              out_illegal <= dec_illegal;
            end
          end
        end
`ifdef ALU_MULDIV_EN
        CALC: begin
          if (cnt != '0) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt - 1'b1;
          end else begin
            state       <= DONE;
            busy        <= 1'b0;
            out_valid   <= 1'b1;
            out_result  <= m_result;
            out_check   <= 1'b0;
            out_illegal <= 1'b0;
          end
        end
        DONE: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32). Define ALU_MULDIV_EN for both
// the design and this bench to exercise the M-extension engine.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_check;
  logic        out_illegal;
  logic        busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        chk;
    logic        ill;
  } vec_t;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_result(out_result), .out_check(out_check),
    .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request for exactly one edge; returns 1 time unit after it.
  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_check !== 1'b0 ||
        out_illegal !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%0b result=%h check=%0b illegal=%0b busy=%0b ready=%0b, required all 0",
               out_valid, out_result, out_check, out_illegal, busy, in_ready);
    end else $display("ok reset: outputs cleared, in_ready=0");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready=%0b, required 1", in_ready);
    end else $display("ok reset_release: in_ready=1");
  endtask

  task automatic run_table(input vec_t v[], input string tag);
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b);
      total++;
      if (out_valid !== 1'b1 || out_result !== v[i].res || out_check !== v[i].chk ||
          out_illegal !== v[i].ill || in_ready !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s %s: valid=%0b result=%h check=%0b illegal=%0b ready=%0b busy=%0b, required valid=1 result=%h check=%0b illegal=%0b ready=1 busy=0",
                 tag, v[i].name, out_valid, out_result, out_check, out_illegal, in_ready, busy,
                 v[i].res, v[i].chk, v[i].ill);
      end else $display("ok %s %s: result=%h check=%0b illegal=%0b",
                        tag, v[i].name, out_result, out_check, out_illegal);
    end
  endtask

  task automatic test_rtype;
    vec_t v[];
    v = new[10];
    v[0] = '{"sub",  2'b10, 7'h20, 3'b000, 32'd5,        32'd7,  32'hFFFF_FFFE, 1'b0, 1'b0};
    v[1] = '{"add",  2'b10, 7'h00, 3'b000, 32'd10,       32'd20, 32'd30,        1'b0, 1'b0};
    v[2] = '{"xor",  2'b10, 7'h00, 3'b100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0};
    v[3] = '{"sll",  2'b10, 7'h00, 3'b001, 32'd1,        32'd33, 32'd2,         1'b0, 1'b0};
    v[4] = '{"srl",  2'b10, 7'h00, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0};
    v[5] = '{"sra",  2'b10, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0};
    v[6] = '{"slt",  2'b10, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1,         1'b0, 1'b0};
    v[7] = '{"sltu", 2'b10, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0,         1'b0, 1'b0};
    v[8] = '{"or",   2'b10, 7'h00, 3'b110, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0, 1'b0};
    v[9] = '{"and",  2'b10, 7'h00, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0};
    run_table(v, "rtype");
  endtask

  task automatic test_itype;
    vec_t v[];
    v = new[5];
    v[0] = '{"addi_f7",  2'b11, 7'h20, 3'b000, 32'd3,         32'd4, 32'd7,         1'b0, 1'b0};
    v[1] = '{"srai",     2'b11, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0};
    v[2] = '{"srli",     2'b11, 7'h00, 3'b101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0};
    v[3] = '{"slli_bad", 2'b11, 7'h20, 3'b001, 32'd1,         32'd4, 32'd0,         1'b0, 1'b1};
    v[4] = '{"ld_add",   2'b00, 7'h20, 3'b111, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0, 1'b0};
    run_table(v, "itype");
  endtask

  task automatic test_branch;
    vec_t v[];
    v = new[8];
    v[0] = '{"bge",  2'b01, 7'h00, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[1] = '{"bgeu", 2'b01, 7'h00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0};
    v[2] = '{"f3_010", 2'b01, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0,       1'b0, 1'b1};
    v[3] = '{"blt",  2'b01, 7'h00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1, 1'b0};
    v[4] = '{"bltu", 2'b01, 7'h00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[5] = '{"beq",  2'b01, 7'h00, 3'b000, 32'd9,         32'd9, 32'd0,         1'b1, 1'b0};
    v[6] = '{"bne",  2'b01, 7'h00, 3'b001, 32'd9,         32'd9, 32'd0,         1'b0, 1'b0};
    v[7] = '{"f3_011", 2'b01, 7'h00, 3'b011, 32'd9,       32'd9, 32'd0,         1'b0, 1'b1};
    run_table(v, "branch");
  endtask

  task automatic test_illegal;
    vec_t v[];
    v = new[3];
    v[0] = '{"f7_40",    2'b10, 7'h40, 3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1};
    v[1] = '{"f7_20_sll", 2'b10, 7'h20, 3'b001, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1};
`ifdef ALU_MULDIV_EN
    v[2] = '{"f7_21",    2'b10, 7'h21, 3'b000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1};
`else
    v[2] = '{"m_disabled", 2'b10, 7'h01, 3'b000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1};
`endif
    run_table(v, "illegal");
  endtask

  task automatic test_back_to_back;
    drive(2'b00, 7'h00, 3'b000, 32'd1, 32'd2);
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd3) begin
      bad++;
      $display("FAIL b2b_first: valid=%0b result=%h, required valid=1 result=00000003", out_valid, out_result);
    end else $display("ok b2b_first: result=%h", out_result);
    drive(2'b10, 7'h20, 3'b000, 32'd9, 32'd4);
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd5) begin
      bad++;
      $display("FAIL b2b_second: valid=%0b result=%h, required valid=1 result=00000005", out_valid, out_result);
    end else $display("ok b2b_second: result=%h", out_result);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pulse: valid=%0b on idle cycle, required 0", out_valid);
    end else $display("ok b2b_pulse: out_valid dropped");
  endtask

`ifdef ALU_MULDIV_EN
  // Issues one M op and follows it to completion (bounded); results are
  // judged by the caller.
  task automatic m_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat,
                      output logic ready_seen, output logic busy_low_seen);
    drive(2'b10, 7'h01, f3, a, b);
    lat = 1;
    ready_seen = in_ready;
    busy_low_seen = !busy;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid !== 1'b1) begin
        if (in_ready !== 1'b0) ready_seen = 1'b1;
        if (busy !== 1'b1) busy_low_seen = 1'b1;
      end
    end
    res = out_result;
    @(posedge clk); #1;
  endtask

  task automatic test_muldiv;
    logic [2:0]  f3s [12] = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b010, 3'b100,
                              3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101};
    logic [31:0] as  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF,
                              32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                              32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7};
    logic [31:0] exp [12] = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFA, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h0,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
    logic [31:0] res;
    int          lat;
    logic        rdy, bl;
    for (int i = 0; i < 12; i++) begin
      m_op(f3s[i], as[i], bs[i], res, lat, rdy, bl);
      total++;
      if (res !== exp[i] || lat != 34 || rdy !== 1'b0 || bl !== 1'b0) begin
        bad++;
        $display("FAIL mext[%0d] f3=%b a=%h b=%h: result=%h latency=%0d ready_seen=%0b busy_dropped=%0b, required result=%h latency=34 ready_seen=0 busy_dropped=0",
                 i, f3s[i], as[i], bs[i], res, lat, rdy, bl, exp[i]);
      end else $display("ok mext[%0d] f3=%b a=%h b=%h: result=%h latency=%0d",
                        i, f3s[i], as[i], bs[i], res, lat);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mext_idle: ready=%0b valid=%0b busy=%0b, required ready=1 valid=0 busy=0",
               in_ready, out_valid, busy);
    end else $display("ok mext_idle: back to idle");
  endtask

  task automatic test_reset_mid;
    logic seen;
    drive(2'b10, 7'h01, 3'b101, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_busy: busy=%0b before reset, required 1", busy);
    end else $display("ok midreset_busy: busy=1");
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: busy=%0b valid=%0b, required 0 0", busy, out_valid);
    end else $display("ok midreset_clear: busy=0");
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midreset_discard: out_valid seen=%0b after reset, required 0", seen);
    end else $display("ok midreset_discard: no stray out_valid");
    drive(2'b00, 7'h00, 3'b000, 32'd1, 32'd1);
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd2) begin
      bad++;
      $display("FAIL midreset_add: valid=%0b result=%h, required valid=1 result=00000002", out_valid, out_result);
    end else $display("ok midreset_add: result=%h", out_result);
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_illegal();
    test_back_to_back();
`ifdef ALU_MULDIV_EN
    test_muldiv();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
